// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, decode classes,
// next-PC sources, ALU operations, opcodes/functs and datapath select codes.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC_R = 4'd6,
    ST_EXEC_I = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_JR     = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILL, CLS_MEM, CLS_R, CLS_JR, CLS_I, CLS_BR, CLS_J
  } cls_e;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multicycle FSM (master) and the datapath (slave).
interface mc_ctrl_fsm_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        stall;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        ir_wr;
  logic        reg_wr;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        mem_rd;
  logic        mem_wr;
  logic        iord;
  logic        alu_srca;
  logic [1:0]  alu_srcb;
  logic [3:0]  alu_op;
  logic        illegal;
  logic [31:0] perf_cyc;
  logic [31:0] perf_ins;

  modport master (
    input  op, funct, zero, mem_ready, stall,
    output pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wd_sel, mem_rd, mem_wr,
           iord, alu_srca, alu_srcb, alu_op, illegal, perf_cyc, perf_ins
  );

  modport slave (
    output op, funct, zero, mem_ready, stall,
    input  pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wd_sel, mem_rd, mem_wr,
           iord, alu_srca, alu_srcb, alu_op, illegal, perf_cyc, perf_ins
  );
endinterface

// File: rtl/mc_ctrl_fsm_instr_decode.sv
// Combinational instruction classifier: op/funct -> execution class,
// ALU operation and B-operand select for the execute state, illegal flag.
module mc_ctrl_fsm_instr_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] alu_srcb_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o      = CLS_ILL;
    alu_op_o   = ALU_ADD;
    alu_srcb_o = SRCB_SEXT;
    case (op_i)
      OP_RTYPE: begin
        alu_srcb_o = SRCB_RT;
        case (funct_i)
          FN_ADDU: cls_o = CLS_R;
          FN_SUBU: begin cls_o = CLS_R; alu_op_o = ALU_SUB; end
          FN_AND:  begin cls_o = CLS_R; alu_op_o = ALU_AND; end
          FN_OR:   begin cls_o = CLS_R; alu_op_o = ALU_OR;  end
          FN_SLT:  begin cls_o = CLS_R; alu_op_o = ALU_SLT; end
          FN_JR:   cls_o = CLS_JR;
          default: cls_o = CLS_ILL;
        endcase
      end
      OP_LW, OP_SW: cls_o = CLS_MEM;
      OP_ORI:   begin cls_o = CLS_I; alu_op_o = ALU_OR; alu_srcb_o = SRCB_ZEXT; end
      OP_ADDIU: cls_o = CLS_I;
      OP_LUI:   begin cls_o = CLS_I; alu_op_o = ALU_LUI; end
      OP_BEQ:   begin cls_o = CLS_BR; alu_op_o = ALU_SUB; alu_srcb_o = SRCB_RT; end
      OP_J, OP_JAL: cls_o = CLS_J;
      default:  cls_o = CLS_ILL;
    endcase
    illegal_o = (cls_o == CLS_ILL);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main control FSM for the MIPS-subset CPU; owns PC update timing.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
//   state  | meaning           state  | meaning
//   FETCH  | IR<=mem[PC], PC+4  EXEC_R | R-type ALU op
//   DECODE | classify, br tgt   EXEC_I | immediate ALU op
//   MEMADR | rs+imm address     ALUWB  | ALU result -> rf
//   MEMRD  | load access        BRANCH | beq compare/redirect
//   MEMWB  | MDR -> rf          JUMP   | j/jal redirect
//   MEMWR  | store access       JR     | PC <= rs
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mc_ctrl_fsm_if.master bus
);

  state_e     state_q, state_d;
  cls_e       dec_cls;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_srcb;
  logic       dec_ill;
  logic       mem_ok;

  assign mem_ok = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  mc_ctrl_fsm_instr_decode u_decode (
    .op_i       (bus.op),
    .funct_i    (bus.funct),
    .cls_o      (dec_cls),
    .alu_op_o   (dec_alu_op),
    .alu_srcb_o (dec_srcb),
    .illegal_o  (dec_ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.stall) begin
      case (state_q)
        ST_FETCH:  if (mem_ok) state_d = ST_DECODE;
        ST_DECODE: begin
          case (dec_cls)
            CLS_MEM: state_d = ST_MEMADR;
            CLS_R:   state_d = ST_EXEC_R;
            CLS_JR:  state_d = ST_JR;
            CLS_I:   state_d = ST_EXEC_I;
            CLS_BR:  state_d = ST_BRANCH;
            CLS_J:   state_d = ST_JUMP;
            default: state_d = ST_FETCH;
          endcase
        end
        ST_MEMADR: state_d = (bus.op == OP_SW) ? ST_MEMWR : ST_MEMRD;
        ST_MEMRD:  if (mem_ok) state_d = ST_MEMWB;
        ST_MEMWR:  if (mem_ok) state_d = ST_FETCH;
        ST_EXEC_R, ST_EXEC_I: state_d = ST_ALUWB;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  // Outputs are forced quiet while rst is high so an aborted access cannot write.
  always_comb begin
    bus.pc_wr    = 1'b0;
    bus.pc_src   = NPC_PLUS4;
    bus.ir_wr    = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.reg_dst  = DST_RT;
    bus.wd_sel   = WD_ALU;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.iord     = 1'b0;
    bus.alu_srca = 1'b0;
    bus.alu_srcb = SRCB_RT;
    bus.alu_op   = ALU_ADD;
    bus.illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          bus.mem_rd   = 1'b1;
          bus.alu_srcb = SRCB_FOUR;
          bus.ir_wr    = mem_ok;
          bus.pc_wr    = mem_ok;
        end
        ST_DECODE: begin
          bus.alu_srcb = SRCB_SEXT;
          bus.illegal  = dec_ill;
        end
        ST_MEMADR: begin
          bus.alu_srca = 1'b1;
          bus.alu_srcb = SRCB_SEXT;
        end
        ST_MEMRD: begin
          bus.mem_rd = 1'b1;
          bus.iord   = 1'b1;
        end
        ST_MEMWB: begin
          bus.reg_wr = 1'b1;
          bus.wd_sel = WD_MDR;
        end
        ST_MEMWR: begin
          bus.mem_wr = 1'b1;
          bus.iord   = 1'b1;
        end
        ST_EXEC_R, ST_EXEC_I: begin
          bus.alu_srca = 1'b1;
          bus.alu_srcb = dec_srcb;
          bus.alu_op   = dec_alu_op;
        end
        ST_ALUWB: begin
          bus.reg_wr  = 1'b1;
          bus.reg_dst = (bus.op == OP_RTYPE) ? DST_RD : DST_RT;
        end
        ST_BRANCH: begin
          bus.alu_srca = 1'b1;
          bus.alu_op   = ALU_SUB;
          bus.pc_src   = NPC_BRANCH;
          bus.pc_wr    = bus.zero;
        end
        ST_JUMP: begin
          bus.pc_wr  = 1'b1;
          bus.pc_src = NPC_JUMP;
          if (bus.op == OP_JAL) begin
            bus.reg_wr  = 1'b1;
            bus.reg_dst = DST_RA;
            bus.wd_sel  = WD_PC4;
          end
        end
        ST_JR: begin
          bus.pc_wr  = 1'b1;
          bus.pc_src = NPC_JR;
        end
        default: ;
      endcase
      if (bus.stall) begin
        bus.pc_wr   = 1'b0;
        bus.ir_wr   = 1'b0;
        bus.reg_wr  = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.illegal = 1'b0;
      end
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] perf_cyc_q, perf_ins_q;
  logic        retire;

  // Illegal DECODE->FETCH is not a retirement.
  assign retire = !bus.stall &&
                  ((state_q inside {ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_JR}) ||
                   (state_q == ST_MEMWR && mem_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cyc_q <= '0;
      perf_ins_q <= '0;
    end else begin
      perf_cyc_q <= perf_cyc_q + 32'd1;
      if (retire) perf_ins_q <= perf_ins_q + 32'd1;
    end
  end

  assign bus.perf_cyc = perf_cyc_q;
  assign bus.perf_ins = perf_ins_q;
`else
  assign bus.perf_cyc = '0;
  assign bus.perf_ins = '0;
`endif

endmodule
